// File: rtl/board_renderer_pkg.sv
// Shared constants for the minesweeper board renderer: window geometry, tile codes and palette.
package board_renderer_pkg;

    localparam int unsigned H_OFFSET_I = 80;
    localparam int unsigned TILE_PX    = 30;
    localparam int unsigned GRID       = 16;

    localparam logic [9:0] H_OFFSET  = 10'(H_OFFSET_I);
    localparam logic [9:0] H_END     = 10'(H_OFFSET_I + GRID * TILE_PX);
    localparam logic [9:0] V_LAST    = 10'(GRID * TILE_PX - 1);
    localparam logic [4:0] TILE_LAST = 5'(TILE_PX - 1);

    localparam logic [3:0] TILE_MINE   = 4'd9;
    localparam logic [3:0] TILE_HIDDEN = 4'd10;
    localparam logic [3:0] TILE_FLAG   = 4'd11;
    localparam logic [3:0] TILE_BOOM   = 4'd12;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK   = 24'h000000;
    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_GREY_LT = 24'hC0C0C0;
    localparam rgb_t RGB_GREY    = 24'h808080;
    localparam rgb_t RGB_BORDER  = 24'h404040;
    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_GREEN   = 24'h008000;
    localparam rgb_t RGB_NAVY    = 24'h000080;
    localparam rgb_t RGB_MAROON  = 24'h800000;
    localparam rgb_t RGB_TEAL    = 24'h008080;

    typedef struct packed {
        logic [4:0] sub_x;
        logic [4:0] sub_y;
        logic       hit;
        logic       active;
        logic       hs;
        logic       vs;
    } stage2_t;

    function automatic logic in_span(input logic [4:0] sub, input logic [4:0] lo, input logic [4:0] hi);
        return (sub >= lo) && (sub <= hi);
    endfunction

endpackage

// File: rtl/board_renderer_tile_glyph.sv
// Combinational glyph lookup: tile code plus in-tile offset to a 24-bit colour.
module board_renderer_tile_glyph
    import board_renderer_pkg::*;
(
    input  logic [3:0] code,
    input  logic [4:0] sub_x,
    input  logic [4:0] sub_y,
    output rgb_t       rgb
);

    logic blk_8;
    logic blk_10;
    logic blk_12;
    logic hilite;

    always_comb begin
        blk_8  = in_span(sub_x, 5'd11, 5'd18) && in_span(sub_y, 5'd11, 5'd18);
        blk_10 = in_span(sub_x, 5'd10, 5'd19) && in_span(sub_y, 5'd10, 5'd19);
        blk_12 = in_span(sub_x, 5'd9, 5'd20) && in_span(sub_y, 5'd9, 5'd20);
        hilite = (sub_x == 5'd1) || (sub_y == 5'd1);

        rgb = RGB_MAGENTA;
        case (code)
            4'd0:        rgb = RGB_GREY_LT;
            4'd1:        rgb = blk_10 ? RGB_BLUE   : RGB_GREY_LT;
            4'd2:        rgb = blk_10 ? RGB_GREEN  : RGB_GREY_LT;
            4'd3:        rgb = blk_10 ? RGB_RED    : RGB_GREY_LT;
            4'd4:        rgb = blk_10 ? RGB_NAVY   : RGB_GREY_LT;
            4'd5:        rgb = blk_10 ? RGB_MAROON : RGB_GREY_LT;
            4'd6:        rgb = blk_10 ? RGB_TEAL   : RGB_GREY_LT;
            4'd7:        rgb = blk_10 ? RGB_BLACK  : RGB_GREY_LT;
            4'd8:        rgb = blk_10 ? RGB_GREY   : RGB_GREY_LT;
            TILE_MINE:   rgb = blk_12 ? RGB_BLACK  : RGB_GREY_LT;
            TILE_HIDDEN: rgb = hilite ? RGB_WHITE  : RGB_GREY;
            TILE_FLAG:   rgb = blk_8  ? RGB_RED    : RGB_GREY;
            TILE_BOOM:   rgb = blk_12 ? RGB_BLACK  : RGB_RED;
            default:     rgb = RGB_MAGENTA;
        endcase
    end

endmodule

// File: rtl/board_renderer.sv
// Pixel-colour stage behind the VGA timing driver: tracks the 16x16 tile grid without division,
// fetches tile codes from board RAM and renders glyph, border and cursor with 3-clk aligned syncs.
module board_renderer
    import board_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xPixel,
    input  logic [9:0] yPixel,
    input  logic       active_pixels,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [3:0] cursor_row,
    input  logic [3:0] cursor_col,
    output logic [7:0] board_addr,
    input  logic [3:0] board_data,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N
);

    logic [9:0] prev_x_q, prev_x_d;
    logic [4:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [3:0] tile_col_q, tile_col_d, tile_row_q, tile_row_d;
    logic       act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    stage2_t    s2_q, s2_d;
    rgb_t       rgb_q, rgb_d;
    logic       blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
    logic       x_step;
    logic       ring, border;
    rgb_t       glyph_rgb;

    always_comb begin
        x_step     = (xPixel != prev_x_q);
        prev_x_d   = xPixel;
        sub_x_d    = sub_x_q;
        tile_col_d = tile_col_q;
        sub_y_d    = sub_y_q;
        tile_row_d = tile_row_q;

        if (xPixel == H_OFFSET) begin
            sub_x_d    = '0;
            tile_col_d = '0;
        end else if (x_step && (xPixel > H_OFFSET) && (xPixel < H_END)) begin
            if (sub_x_q == TILE_LAST) begin
                sub_x_d    = '0;
                tile_col_d = tile_col_q + 4'd1;
            end else begin
                sub_x_d = sub_x_q + 5'd1;
            end
        end

        if (x_step && (xPixel == '0)) begin
            if (yPixel == '0) begin
                sub_y_d    = '0;
                tile_row_d = '0;
            end else if (yPixel <= V_LAST) begin
                if (sub_y_q == TILE_LAST) begin
                    sub_y_d    = '0;
                    tile_row_d = tile_row_q + 4'd1;
                end else begin
                    sub_y_d = sub_y_q + 5'd1;
                end
            end
        end

        act1_d = active_pixels;
        hs1_d  = hsync_in;
        vs1_d  = vsync_in;
    end

    assign board_addr = {tile_row_q, tile_col_q};

    // The RAM's own output register holds the stage-2 tile code, so only coordinates are piped here.
    always_comb begin
        s2_d.sub_x  = sub_x_q;
        s2_d.sub_y  = sub_y_q;
        s2_d.hit    = (tile_row_q == cursor_row) && (tile_col_q == cursor_col);
        s2_d.active = act1_q;
        s2_d.hs     = hs1_q;
        s2_d.vs     = vs1_q;
    end

    board_renderer_tile_glyph u_tile_glyph (
        .code  (board_data),
        .sub_x (s2_q.sub_x),
        .sub_y (s2_q.sub_y),
        .rgb   (glyph_rgb)
    );

    always_comb begin
        ring   = (s2_q.sub_x <= 5'd1) || (s2_q.sub_x >= 5'd28) ||
                 (s2_q.sub_y <= 5'd1) || (s2_q.sub_y >= 5'd28);
        border = (s2_q.sub_x == 5'd0) || (s2_q.sub_x == TILE_LAST) ||
                 (s2_q.sub_y == 5'd0) || (s2_q.sub_y == TILE_LAST);
        if (!s2_q.active) begin
            rgb_d = RGB_BLACK;
        end else if (s2_q.hit && ring) begin
            rgb_d = RGB_YELLOW;
        end else if (border) begin
            rgb_d = RGB_BORDER;
        end else begin
            rgb_d = glyph_rgb;
        end
        blank_d = s2_q.active;
        hs_d    = s2_q.hs;
        vs_d    = s2_q.vs;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_x_q   <= '0;
            sub_x_q    <= '0;
            sub_y_q    <= '0;
            tile_col_q <= '0;
            tile_row_q <= '0;
            act1_q     <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            s2_q       <= '{sub_x: '0, sub_y: '0, hit: 1'b0, active: 1'b0, hs: 1'b1, vs: 1'b1};
            rgb_q      <= '0;
            blank_q    <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
        end else begin
            prev_x_q   <= prev_x_d;
            sub_x_q    <= sub_x_d;
            sub_y_q    <= sub_y_d;
            tile_col_q <= tile_col_d;
            tile_row_q <= tile_row_d;
            act1_q     <= act1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            s2_q       <= s2_d;
            rgb_q      <= rgb_d;
            blank_q    <= blank_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_BLANK_N           = blank_q;
    assign VGA_HS                = hs_q;
    assign VGA_VS                = vs_q;

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: a compressed VGA scan feeds the DUT, a reference model derived
// from pixel coordinates predicts colour/sync/address, and a monitor compares as outputs emerge.
module tb_board_renderer;

    logic       clk           = 1'b0;
    logic       rst           = 1'b0;
    logic [9:0] xPixel        = '0;
    logic [9:0] yPixel        = '0;
    logic       active_pixels = 1'b0;
    logic       hsync_in      = 1'b1;
    logic       vsync_in      = 1'b1;
    logic [3:0] cursor_row    = '0;
    logic [3:0] cursor_col    = '0;
    logic [7:0] board_addr;
    logic [3:0] board_data;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N;

    logic [3:0] ram [256];
    bit         full_line [480];
    bit         synced = 1'b0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
        bit          rgb_chk;
        logic        hs;
        logic        vs;
        logic        blank;
    } exp_t;

    typedef struct {
        int x;
        int y;
        int addr;
        bit chk;
    } addr_t;

    exp_t  exp_q [$];
    addr_t addr_q [$];

    always #5 clk = ~clk;

    board_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .xPixel        (xPixel),
        .yPixel        (yPixel),
        .active_pixels (active_pixels),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .board_addr    (board_addr),
        .board_data    (board_data),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .VGA_HS        (VGA_HS),
        .VGA_VS        (VGA_VS),
        .VGA_BLANK_N   (VGA_BLANK_N)
    );

    // Registered board RAM: data follows the address by one clock.
    always_ff @(posedge clk) board_data <= ram[board_addr];

    function automatic bit centred(input int sx, input int sy, input int n);
        int lo;
        lo = (30 - n) / 2;
        return (sx >= lo) && (sx < lo + n) && (sy >= lo) && (sy < lo + n);
    endfunction

    function automatic logic [23:0] number_colour(input int code);
        case (code)
            1:       return 24'h0000FF;
            2:       return 24'h008000;
            3:       return 24'hFF0000;
            4:       return 24'h000080;
            5:       return 24'h800000;
            6:       return 24'h008080;
            7:       return 24'h000000;
            default: return 24'h808080;
        endcase
    endfunction

    function automatic logic [23:0] ref_colour(input int x, input int y);
        int c, sx, r, sy, code;
        c    = (x - 80) / 30;
        sx   = (x - 80) % 30;
        r    = y / 30;
        sy   = y % 30;
        code = int'(ram[r * 16 + c]);
        if (r == int'(cursor_row) && c == int'(cursor_col) &&
            (sx < 2 || sx > 27 || sy < 2 || sy > 27))
            return 24'hFFFF00;
        if (sx == 0 || sx == 29 || sy == 0 || sy == 29)
            return 24'h404040;
        if (code == 0)                return 24'hC0C0C0;
        if (code >= 1 && code <= 8)   return centred(sx, sy, 10) ? number_colour(code) : 24'hC0C0C0;
        if (code == 9)                return centred(sx, sy, 12) ? 24'h000000 : 24'hC0C0C0;
        if (code == 10)               return (sx == 1 || sy == 1) ? 24'hFFFFFF : 24'h808080;
        if (code == 11)               return centred(sx, sy, 8) ? 24'hFF0000 : 24'h808080;
        if (code == 12)               return centred(sx, sy, 12) ? 24'h000000 : 24'hFF0000;
        return 24'hFF00FF;
    endfunction

    task automatic check(input string name, input int x, input int y,
                         input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at x=%0d y=%0d: got %06h expected %06h", name, x, y, got, want);
        end
    endtask

    task automatic step(input int x, input int y);
        exp_t  e;
        addr_t a;
        bit    act;
        @(negedge clk);
        act = (x >= 80) && (x < 560) && (y < 480);
        if (x == 0 && y == 0) synced = 1'b1;
        xPixel        = 10'(x);
        yPixel        = 10'(y);
        active_pixels = act;
        hsync_in      = !(x >= 656 && x < 752);
        vsync_in      = !(y == 490 || y == 491);
        if (rst) begin
            e.x       = x;
            e.y       = y;
            e.rgb     = act ? (synced ? ref_colour(x, y) : 24'h0) : 24'h0;
            e.rgb_chk = synced || !act;
            e.hs      = hsync_in;
            e.vs      = vsync_in;
            e.blank   = act;
            exp_q.push_back(e);
            a.x    = x;
            a.y    = y;
            a.addr = act ? ((y / 30) * 16 + (x - 80) / 30) : 0;
            a.chk  = synced && act;
            addr_q.push_back(a);
        end
    endtask

    task automatic pixel(input int x, input int y);
        step(x, y);
        step(x, y);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        synced = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (4) begin
            @(negedge clk);
            check("rst_rgb",   int'(xPixel), int'(yPixel), {VGA_R, VGA_G, VGA_B}, 24'h0);
            check("rst_blank", int'(xPixel), int'(yPixel), 24'(VGA_BLANK_N), 24'h0);
            check("rst_hs",    int'(xPixel), int'(yPixel), 24'(VGA_HS), 24'h1);
            check("rst_vs",    int'(xPixel), int'(yPixel), 24'(VGA_VS), 24'h1);
            check("rst_addr",  int'(xPixel), int'(yPixel), 24'(board_addr), 24'h0);
        end
        rst = 1'b1;
    endtask

    // Lines not marked full only visit the x values needed to step rows and toggle hsync.
    task automatic run_frame(input int reset_y);
        for (int y = 0; y < 500; y++) begin
            if (y < 480 && full_line[y]) begin
                pixel(0, y);
                pixel(79, y);
                for (int x = 80; x < 560; x++) begin
                    pixel(x, y);
                    if (y == reset_y && x == 300) do_reset();
                end
                pixel(560, y);
                pixel(700, y);
                pixel(799, y);
            end else begin
                pixel(0, y);
                pixel(79, y);
                pixel(560, y);
                pixel(700, y);
            end
        end
    endtask

    initial begin : monitor
        exp_t  e;
        addr_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() >= 3) begin
                e = exp_q.pop_front();
                check("hs",    e.x, e.y, 24'(VGA_HS), 24'(e.hs));
                check("vs",    e.x, e.y, 24'(VGA_VS), 24'(e.vs));
                check("blank", e.x, e.y, 24'(VGA_BLANK_N), 24'(e.blank));
                if (e.rgb_chk) check("rgb", e.x, e.y, {VGA_R, VGA_G, VGA_B}, e.rgb);
            end
            if (addr_q.size() >= 1) begin
                a = addr_q.pop_front();
                if (a.chk) check("board_addr", a.x, a.y, 24'(board_addr), 24'(a.addr));
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 256; i++) ram[i] = 4'd3;
        ram[0]     = 4'd11;
        cursor_row = 4'd2;
        cursor_col = 4'd5;
        for (int y = 0; y < 480; y++) full_line[y] = 1'b0;
        full_line[0]   = 1'b1;
        full_line[15]  = 1'b1;
        full_line[29]  = 1'b1;
        full_line[30]  = 1'b1;
        full_line[61]  = 1'b1;
        full_line[200] = 1'b1;
        full_line[479] = 1'b1;

        do_reset();
        run_frame(200);

        cursor_row = 4'd0;
        cursor_col = 4'd0;
        run_frame(-1);

        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 256; i++) ram[i] = 4'($urandom_range(0, 15));
            cursor_row = 4'($urandom_range(0, 15));
            cursor_col = 4'($urandom_range(0, 15));
            for (int y = 0; y < 480; y++) full_line[y] = ($urandom_range(0, 47) == 0);
            full_line[0]   = 1'b1;
            full_line[479] = 1'b1;
            run_frame(-1);
        end

        repeat (8) step(0, 499);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
